// File: rtl/stack_game_pkg.sv
// Shared types and constants for the stacking-game scoring path.
package stack_game_pkg;

  localparam int unsigned DEF_PERFECT_BONUS = 8;
  localparam int unsigned DEF_STREAK_MAX    = 4;

  // Placement fields are carried at a fixed width; narrower inputs are zero-extended.
  localparam int unsigned PLC_BLK_W = 8;
  localparam int unsigned PLC_HGT_W = 8;

  typedef struct packed {
    logic                 stacked;
    logic [PLC_BLK_W-1:0] blocks_placed;
    logic [PLC_HGT_W-1:0] height;
  } placement_t;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stack_point_calc.sv
// Combinational point award for one placement given the streak in force before it.
module stack_point_calc
  import stack_game_pkg::*;
#(
  parameter int unsigned BLK_W         = 2,
  parameter int unsigned STREAK_W      = 3,
  parameter int unsigned PTS_W         = 7,
  parameter int unsigned PERFECT_BONUS = DEF_PERFECT_BONUS
) (
  input  placement_t          plc,
  input  logic [STREAK_W-1:0] streak_old,
  output logic [PTS_W-1:0]    pts_c,
  output logic                perfect_c
);

  localparam logic [PLC_BLK_W-1:0] MAX_BLK = PLC_BLK_W'((1 << BLK_W) - 1);

  logic [PTS_W-1:0] base;

  // PTS_W is sized for the largest product, so no term can overflow here.
  always_comb begin
    perfect_c = plc.stacked & (plc.blocks_placed == MAX_BLK);
    base      = PTS_W'(plc.blocks_placed)
              * (PTS_W'(plc.height) + PTS_W'(1))
              * PTS_W'(streak_old);
    pts_c     = '0;
    if (plc.stacked) begin
      pts_c = base + (perfect_c ? PTS_W'(PERFECT_BONUS) : PTS_W'(0));
    end
  end

endmodule

// File: rtl/stack_score_engine.sv
// Two-stage scoring pipeline: point award + streak/game-over, then saturating accumulate
// with high-score tracking.
module stack_score_engine
  import stack_game_pkg::*;
#(
  parameter int unsigned BLK_W         = 2,
  parameter int unsigned HGT_W         = 3,
  parameter int unsigned STREAK_MAX    = DEF_STREAK_MAX,
  parameter int unsigned PERFECT_BONUS = DEF_PERFECT_BONUS,
  parameter int unsigned SCORE_W       = 16,
  localparam int unsigned MAX_BLK      = (1 << BLK_W) - 1,
  localparam int unsigned PTS_W        =
    clog2(MAX_BLK * (1 << HGT_W) * STREAK_MAX + PERFECT_BONUS + 1),
  localparam int unsigned STREAK_W     = clog2(STREAK_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_clear,
  input  logic                place_valid,
  input  logic                stacked,
  input  logic [BLK_W-1:0]    blocks_placed,
  input  logic [HGT_W-1:0]    height,
  output logic                pnt_valid,
  output logic [PTS_W-1:0]    pnt_output,
  output logic [STREAK_W-1:0] streak,
  output logic [SCORE_W-1:0]  score,
  output logic                score_sat,
  output logic [SCORE_W-1:0]  hi_score,
  output logic                game_over
);

  localparam int unsigned SUM_W = ((PTS_W > SCORE_W) ? PTS_W : SCORE_W) + 1;

  placement_t          plc;
  logic [PTS_W-1:0]    pts;
  logic                perfect;
  logic                accept;
  logic                miss;
  logic [STREAK_W-1:0] streak_nxt;
  logic [SUM_W-1:0]    sum;
  logic                sat_hit;
  logic [SCORE_W-1:0]  score_nxt;

  assign plc.stacked       = stacked;
  assign plc.blocks_placed = PLC_BLK_W'(blocks_placed);
  assign plc.height        = PLC_HGT_W'(height);

  stack_point_calc #(
    .BLK_W         (BLK_W),
    .STREAK_W      (STREAK_W),
    .PTS_W         (PTS_W),
    .PERFECT_BONUS (PERFECT_BONUS)
  ) u_point_calc (
    .plc        (plc),
    .streak_old (streak),
    .pts_c      (pts),
    .perfect_c  (perfect)
  );

  always_comb begin
    accept     = place_valid & ~game_over & ~game_clear;
    miss       = ~stacked | (blocks_placed == '0);
    streak_nxt = STREAK_W'(1);
    if (perfect) begin
      streak_nxt = (streak == STREAK_W'(STREAK_MAX)) ? streak : streak + STREAK_W'(1);
    end
    sum       = SUM_W'(score) + SUM_W'(pnt_output);
    sat_hit   = sum >= SUM_W'({SCORE_W{1'b1}});
    score_nxt = sat_hit ? {SCORE_W{1'b1}} : SCORE_W'(sum);
  end

  // Stage 1: award points, advance streak, latch game over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pnt_valid  <= 1'b0;
      pnt_output <= '0;
      streak     <= STREAK_W'(1);
      game_over  <= 1'b0;
    end else if (game_clear) begin
      pnt_valid <= 1'b0;
      streak    <= STREAK_W'(1);
      game_over <= 1'b0;
    end else begin
      pnt_valid <= accept;
      if (accept) begin
        pnt_output <= pts;
        streak     <= streak_nxt;
        if (miss) game_over <= 1'b1;
      end
    end
  end

  // Stage 2: saturating accumulate; a clear drops whatever stage 1 holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score     <= '0;
      score_sat <= 1'b0;
      hi_score  <= '0;
    end else if (game_clear) begin
      score     <= '0;
      score_sat <= 1'b0;
    end else if (pnt_valid) begin
      score     <= score_nxt;
      score_sat <= score_sat | sat_hit;
      if (score_nxt > hi_score) hi_score <= score_nxt;
    end
  end

endmodule

// File: tb/tb_stack_score_engine.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized traffic against a behavioural model (default and 6-bit score instances).
module tb_stack_score_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_clear = 1'b0;
  logic       place_valid = 1'b0;
  logic       stacked = 1'b0;
  logic [1:0] blocks_placed = 2'd0;
  logic [2:0] height = 3'd0;

  logic        pnt_valid, score_sat, game_over;
  logic [6:0]  pnt_output;
  logic [2:0]  streak;
  logic [15:0] score, hi_score;

  logic        s_pnt_valid, s_score_sat, s_game_over;
  logic [6:0]  s_pnt_output;
  logic [2:0]  s_streak;
  logic [5:0]  s_score, s_hi_score;

  stack_score_engine dut (
    .clk(clk), .rst_n(rst_n), .game_clear(game_clear), .place_valid(place_valid),
    .stacked(stacked), .blocks_placed(blocks_placed), .height(height),
    .pnt_valid(pnt_valid), .pnt_output(pnt_output), .streak(streak), .score(score),
    .score_sat(score_sat), .hi_score(hi_score), .game_over(game_over)
  );

  stack_score_engine #(.SCORE_W(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .game_clear(game_clear), .place_valid(place_valid),
    .stacked(stacked), .blocks_placed(blocks_placed), .height(height),
    .pnt_valid(s_pnt_valid), .pnt_output(s_pnt_output), .streak(s_streak), .score(s_score),
    .score_sat(s_score_sat), .hi_score(s_hi_score), .game_over(s_game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: index 0 = 16-bit score, index 1 = 6-bit score.
  int m_pv, m_po, m_streak, m_go;
  int m_score[2], m_sat[2], m_hi[2];
  int smax[2] = '{65535, 63};

  typedef struct {
    bit clr; bit pv; bit st; int blk; int hgt;
    bit e_pv; int e_pts; int e_str; int e_score; bit e_go;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = 0; m_po = 0; m_streak = 1; m_go = 0;
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_sat[k] = 0; m_hi[k] = 0;
    end
  endtask

  task automatic model_step();
    int s;
    bit perf;
    if (game_clear) begin
      m_pv = 0; m_streak = 1; m_go = 0;
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_sat[k] = 0;
      end
    end else begin
      if (m_pv != 0) begin
        for (int k = 0; k < 2; k++) begin
          s = m_score[k] + m_po;
          if (s >= smax[k]) begin
            s = smax[k];
            m_sat[k] = 1;
          end
          m_score[k] = s;
          if (s > m_hi[k]) m_hi[k] = s;
        end
      end
      if (place_valid && m_go == 0) begin
        perf = stacked && (int'(blocks_placed) == 3);
        m_po = stacked ? int'(blocks_placed) * (int'(height) + 1) * m_streak + (perf ? 8 : 0) : 0;
        m_pv = 1;
        m_streak = perf ? ((m_streak + 1 > 4) ? 4 : m_streak + 1) : 1;
        if (!stacked || blocks_placed == 2'd0) m_go = 1;
      end else begin
        m_pv = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("pnt_valid", 32'(pnt_valid), 32'(m_pv));
    if (m_pv != 0) chk("pnt_output", 32'(pnt_output), 32'(m_po));
    chk("streak", 32'(streak), 32'(m_streak));
    chk("game_over", 32'(game_over), 32'(m_go));
    chk("score", 32'(score), 32'(m_score[0]));
    chk("score_sat", 32'(score_sat), 32'(m_sat[0]));
    chk("hi_score", 32'(hi_score), 32'(m_hi[0]));
    chk("s_pnt_valid", 32'(s_pnt_valid), 32'(m_pv));
    if (m_pv != 0) chk("s_pnt_output", 32'(s_pnt_output), 32'(m_po));
    chk("s_streak", 32'(s_streak), 32'(m_streak));
    chk("s_game_over", 32'(s_game_over), 32'(m_go));
    chk("s_score", 32'(s_score), 32'(m_score[1]));
    chk("s_score_sat", 32'(s_score_sat), 32'(m_sat[1]));
    chk("s_hi_score", 32'(s_hi_score), 32'(m_hi[1]));
  endtask

  // Drive one cycle's inputs, step the model on the edge, compare on the falling edge.
  task automatic do_cycle(input bit clr, input bit pv, input bit st, input int blk, input int hgt);
    game_clear = clr; place_valid = pv; stacked = st;
    blocks_placed = 2'(blk); height = 3'(hgt);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    tbl[0]  = '{0, 1, 1, 1, 3, 1,  4, 1,  0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,  0, 1,  4, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0,  0, 1,  0, 0};
    tbl[3]  = '{0, 1, 1, 3, 0, 1, 11, 2,  0, 0};
    tbl[4]  = '{0, 1, 1, 3, 0, 1, 14, 3, 11, 0};
    tbl[5]  = '{0, 1, 1, 3, 0, 1, 17, 4, 25, 0};
    tbl[6]  = '{0, 1, 1, 3, 0, 1, 20, 4, 42, 0};
    tbl[7]  = '{0, 1, 1, 3, 0, 1, 20, 4, 62, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,  0, 4, 82, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 1,  0, 1, 82, 1};
    tbl[10] = '{0, 1, 1, 3, 7, 0,  0, 1, 82, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0,  0, 1, 82, 1};
    tbl[12] = '{1, 1, 1, 3, 0, 0,  0, 1,  0, 0};
    tbl[13] = '{0, 1, 1, 1, 0, 1,  1, 1,  0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0,  0, 1,  0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0,  0, 1,  0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pnt_valid", 32'(pnt_valid), 0);
    chk("rst_streak", 32'(streak), 1);
    chk("rst_score", 32'(score), 0);
    chk("rst_hi_score", 32'(hi_score), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_cycle(tbl[i].clr, tbl[i].pv, tbl[i].st, tbl[i].blk, tbl[i].hgt);
      chk($sformatf("tbl%0d_pnt_valid", i), 32'(pnt_valid), 32'(tbl[i].e_pv));
      if (tbl[i].e_pv) chk($sformatf("tbl%0d_pnt_output", i), 32'(pnt_output), 32'(tbl[i].e_pts));
      chk($sformatf("tbl%0d_streak", i), 32'(streak), 32'(tbl[i].e_str));
      chk($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].e_score));
      chk($sformatf("tbl%0d_game_over", i), 32'(game_over), 32'(tbl[i].e_go));
    end
    chk("tbl_hi_score_kept", 32'(hi_score), 82);

    // Saturation: perfect stacks at the top row award 32, 56, 80, 104.
    do_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 1, 3, 7);
    repeat (2) do_cycle(0, 0, 0, 0, 0);
    chk("sat_s_score", 32'(s_score), 63);
    chk("sat_s_score_sat", 32'(s_score_sat), 1);
    chk("sat_s_hi_score", 32'(s_hi_score), 63);
    chk("sat_wide_score", 32'(score), 272);
    chk("sat_wide_score_sat", 32'(score_sat), 0);
    do_cycle(1, 0, 0, 0, 0);
    chk("clr_s_hi_kept", 32'(s_hi_score), 63);
    chk("clr_s_score_sat", 32'(s_score_sat), 0);

    // Async reset with a placement in flight.
    do_cycle(0, 1, 1, 3, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pnt_valid", 32'(pnt_valid), 0);
    chk("arst_streak", 32'(streak), 1);
    chk("arst_hi_score", 32'(hi_score), 0);
    chk("arst_s_score", 32'(s_score), 0);
    model_reset();
    #1 rst_n = 1'b1;
    do_cycle(0, 0, 0, 0, 0);
    chk("arst_dropped_score", 32'(score), 0);

    for (int n = 0; n < 3000; n++) begin
      bit clr;
      clr = ($urandom_range(0, 31) == 0) || (m_go != 0 && $urandom_range(0, 3) == 0);
      do_cycle(clr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0),
               ($urandom_range(0, 1) != 0) ? 3 : int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_score_engine.md
Name: stack_score_engine

Overview:
- Clocked, parametrised successor to the combinational point awarder in the stacking game.
- Per placement, computes points from these factors:
  - blocks placed
  - height
  - a perfect-stack streak multiplier
  - a perfect bonus
- Registers those points, then accumulates them into a saturating score.
- Also tracks the high score and detects game over.
- Sits between the placement/collision logic and the score display driver.

Parameters:
- BLK_W, 2, width of blocks_placed; MAX_BLK = 2^BLK_W-1 counts as a perfect placement.
- HGT_W, 3, width of height; height factor is height+1.
- STREAK_MAX, 4, streak multiplier cap (>=1).
- PERFECT_BONUS, 8, points added on a perfect placement.
- SCORE_W, 16, width of score and hi_score.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- game_clear  in  1  synchronous clear for a new game (hi_score kept).
- place_valid  in  1  one-cycle strobe; placement fields valid.
- stacked  in  1  1 = placement landed on the stack.
- blocks_placed  in  BLK_W  blocks remaining on the row after placement.
- height  in  HGT_W  row index of the placement (0 = bottom).
- pnt_valid  out  1  pnt_output valid this cycle.
- pnt_output  out  PTS_W  points awarded for the last accepted placement.
- streak  out  clog2(STREAK_MAX+1)  current multiplier, 1..STREAK_MAX.
- score  out  SCORE_W  accumulated score, saturating.
- score_sat  out  1  sticky; score has hit all-ones.
- hi_score  out  SCORE_W  best score since reset.
- game_over  out  1  sticky; set on a total miss.

Behaviour:
- PTS_W is a localparam, sized to fit MAX_BLK*2^HGT_W*STREAK_MAX+PERFECT_BONUS.
- Reset (rst_n=0, async):
  - pnt_valid=0, pnt_output=0, score=0, score_sat=0, hi_score=0, game_over=0.
  - streak=1.
  - Pipeline valids cleared.
- Accept: placement accepted at edge N when place_valid=1, game_over=0 and game_clear=0. Otherwise it is ignored (no state change).
- Stage 1 (edge N):
  - pnt_valid=1 for exactly one cycle (N+1).
  - pnt_output computed as:
    - perfect = stacked & (blocks_placed==MAX_BLK).
    - If stacked=1: pts = blocks_placed*(height+1)*streak_old + (perfect ? PERFECT_BONUS : 0).
    - If stacked=0: pts = 0.
    - streak_old is the streak value before edge N.
  - Streak update at edge N:
    - perfect: streak = min(streak+1, STREAK_MAX).
    - stacked non-perfect, or stacked=0: streak = 1.
  - Game over: if stacked=0 or blocks_placed=0, game_over=1 at N+1.
- Stage 2 (edge N+1):
  - score = min(score+pnt_output, 2^SCORE_W-1).
  - score_sat=1 if the add saturates.
  - hi_score = max(hi_score, new score), updated on the same edge. Latency place_valid→score is 2 cycles.
- Throughput: one placement per cycle. Back-to-back strobes each accumulate; no placement is lost.
- game_clear=1 at any edge:
  - score=0, score_sat=0, streak=1, game_over=0.
  - pnt_valid=0 and both pipeline stages flushed, so an in-flight placement is never added.
  - hi_score unchanged.
  - Clear wins over a simultaneous place_valid.
- Placement in the cycle game_over rises: the offending placement itself still flows through stage 2 (pts 0). Later strobes are ignored.
- Async reset mid-operation: all state returns to reset values immediately, and the in-flight placement is dropped.
- Arithmetic: all math is unsigned and sized to PTS_W/SCORE_W+1 before compare, with no intermediate truncation.

Decomposition:
- Package stack_game_pkg holds:
  - default values for PERFECT_BONUS and STREAK_MAX;
  - a clog2 function;
  - a placement_t struct {stacked, blocks_placed, height}.
- One combinational sub-module, stack_point_calc, computes pts and perfect from placement_t and streak_old.
- The parent holds streak, pipeline, accumulator, hi_score and game_over registers.

Test Plan:
- Reset check: assert rst_n=0 mid-run → all outputs 0, streak=1, immediately (async).
- Non-perfect placement: stacked=1, blocks=1, height=3 → pnt_output=4 at N+1; score=4 at N+2; streak stays 1.
- Five consecutive perfect placements: blocks=3, height=0, back-to-back strobes →
  - pnt_output 11, 14, 17, 20, 20 (capped);
  - score 11, 25, 42, 62, 82;
  - streak 2, 3, 4, 4, 4.
- Total miss: stacked=0, blocks=0 → pnt_output=0, game_over=1. A following strobe (blocks=3, height=7) is ignored and score is unchanged.
- Saturation with SCORE_W=6: repeated perfect stacks at height 7 → score holds at 63, score_sat=1, hi_score=63.
- Clear with a placement in flight: game_clear on edge N+1 after a strobe at N →
  - score=0, pnt_valid=0, and the strobe is never added;
  - hi_score keeps its prior value;
  - simultaneous clear+strobe is dropped.
